// File: rtl/axil_dma_pkg.sv
// Shared types and constants for the boot-time AXI4-Lite copy engine.
package axil_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B,
    ST_DONE,
    ST_ERR
  } dma_state_t;

  localparam logic [1:0]  RESP_OKAY              = 2'b00;
  localparam logic [31:0] DEFAULT_STOP_SIGNATURE = 32'hBDED_E000;

endpackage

// File: rtl/axil_boot_dma.sv
// Boot DMA: copies words one at a time from SRC_BASE to DST_BASE over AXI4-Lite, then releases the CPU.
// Optional running checksum of written words is enabled by defining AXIL_BOOT_DMA_CHECKSUM_EN.
module axil_boot_dma
  import axil_dma_pkg::*;
#(
  parameter logic [31:0] SRC_BASE       = 32'h0000_2000,
  parameter logic [31:0] DST_BASE       = 32'h0000_4000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter bit          STOP_SIG_EN    = 1'b1,
  parameter logic [31:0] STOP_SIGNATURE = DEFAULT_STOP_SIGNATURE,
  parameter bit          AUTO_START     = 1'b1,
  localparam int         CW             = $clog2(MAX_WORDS + 1)
) (
  input  logic          m_axi_aclk,
  input  logic          m_axi_aresetn,
  input  logic          start,
  output logic [31:0]   m_axi_araddr,
  output logic          m_axi_arvalid,
  input  logic          m_axi_arready,
  input  logic [31:0]   m_axi_rdata,
  input  logic [1:0]    m_axi_rresp,
  input  logic          m_axi_rvalid,
  output logic          m_axi_rready,
  output logic [31:0]   m_axi_awaddr,
  output logic          m_axi_awvalid,
  input  logic          m_axi_awready,
  output logic [31:0]   m_axi_wdata,
  output logic [3:0]    m_axi_wstrb,
  output logic          m_axi_wvalid,
  input  logic          m_axi_wready,
  input  logic [1:0]    m_axi_bresp,
  input  logic          m_axi_bvalid,
  output logic          m_axi_bready,
  output logic          cpu_fetch_enable,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] word_count,
  output logic [31:0]   checksum
);

  localparam logic [CW-1:0] MAX_WC = CW'(MAX_WORDS);

  dma_state_t    state;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic          aw_fin;
  logic          w_fin;
  logic [CW-1:0] wc_inc;

  // A channel is finished once its valid has dropped or is being accepted this cycle.
  assign aw_fin      = !m_axi_awvalid || m_axi_awready;
  assign w_fin       = !m_axi_wvalid || m_axi_wready;
  assign wc_inc      = word_count + 1'b1;
  assign m_axi_wstrb = 4'b1111;

`ifdef AXIL_BOOT_DMA_CHECKSUM_EN
  logic [31:0] checksum_reg;
  assign checksum = checksum_reg;
`else
  assign checksum = 32'h0;
`endif

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state            <= ST_IDLE;
      src_addr         <= SRC_BASE;
      dst_addr         <= DST_BASE;
      m_axi_araddr     <= '0;
      m_axi_arvalid    <= 1'b0;
      m_axi_rready     <= 1'b0;
      m_axi_awaddr     <= '0;
      m_axi_awvalid    <= 1'b0;
      m_axi_wdata      <= '0;
      m_axi_wvalid     <= 1'b0;
      m_axi_bready     <= 1'b0;
      cpu_fetch_enable <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      word_count       <= '0;
`ifdef AXIL_BOOT_DMA_CHECKSUM_EN
      checksum_reg     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (AUTO_START || start) begin
            state         <= ST_AR;
            m_axi_araddr  <= src_addr;
            m_axi_arvalid <= 1'b1;
            busy          <= 1'b1;
          end
        end
        ST_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_R;
          end
        end
        ST_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (m_axi_rresp != RESP_OKAY) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else if (STOP_SIG_EN && (m_axi_rdata == STOP_SIGNATURE)) begin
              state            <= ST_DONE;
              busy             <= 1'b0;
              done             <= 1'b1;
              cpu_fetch_enable <= 1'b1;
            end else begin
              m_axi_wdata   <= m_axi_rdata;
              m_axi_awaddr  <= dst_addr;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= ST_WR;
            end
          end
        end
        ST_WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            m_axi_bready <= 1'b1;
            state        <= ST_B;
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != RESP_OKAY) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              src_addr   <= src_addr + 32'd4;
              dst_addr   <= dst_addr + 32'd4;
              word_count <= wc_inc;
`ifdef AXIL_BOOT_DMA_CHECKSUM_EN
              checksum_reg <= checksum_reg + m_axi_wdata;
`endif
              // The count limit is checked before any further read, so a signature past it is never fetched.
              if (wc_inc == MAX_WC) begin
                state            <= ST_DONE;
                busy             <= 1'b0;
                done             <= 1'b1;
                cpu_fetch_enable <= 1'b1;
              end else begin
                state         <= ST_AR;
                m_axi_araddr  <= src_addr + 32'd4;
                m_axi_arvalid <= 1'b1;
              end
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        ST_ERR:  state <= ST_ERR;
        default: begin
          state <= ST_ERR;
          busy  <= 1'b0;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_boot_dma.sv
// Directed bench: three DMA configurations, each against its own small AXI4-Lite slave memory model.
module tb_axil_boot_dma;

  localparam logic [31:0] SIG = 32'hBDED_E000;
`ifdef AXIL_BOOT_DMA_CHECKSUM_EN
  localparam logic [31:0] SUM_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SUM_MASK = 32'h0;
`endif

  logic        clk;
  logic [2:0]  rst_n, start;
  logic [2:0]  arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [2:0]  cfe, busy, done, error;
  logic [31:0] araddr [3];
  logic [31:0] rdata [3];
  logic [31:0] awaddr [3];
  logic [31:0] wdata [3];
  logic [31:0] checksum [3];
  logic [1:0]  rresp [3];
  logic [1:0]  bresp [3];
  logic [3:0]  wstrb [3];
  logic [10:0] wc_a, wc_c;
  logic [2:0]  wc_b;

  int aw_dly [3];
  int w_dly [3];
  int err_rd [3];
  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axil_boot_dma #(.STOP_SIG_EN(1'b1), .MAX_WORDS(1024), .AUTO_START(1'b1)) dut_a (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n[0]), .start(start[0]),
    .m_axi_araddr(araddr[0]), .m_axi_arvalid(arvalid[0]), .m_axi_arready(arready[0]),
    .m_axi_rdata(rdata[0]), .m_axi_rresp(rresp[0]), .m_axi_rvalid(rvalid[0]), .m_axi_rready(rready[0]),
    .m_axi_awaddr(awaddr[0]), .m_axi_awvalid(awvalid[0]), .m_axi_awready(awready[0]),
    .m_axi_wdata(wdata[0]), .m_axi_wstrb(wstrb[0]), .m_axi_wvalid(wvalid[0]), .m_axi_wready(wready[0]),
    .m_axi_bresp(bresp[0]), .m_axi_bvalid(bvalid[0]), .m_axi_bready(bready[0]),
    .cpu_fetch_enable(cfe[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
    .word_count(wc_a), .checksum(checksum[0])
  );

  axil_boot_dma #(.STOP_SIG_EN(1'b0), .MAX_WORDS(4), .AUTO_START(1'b1)) dut_b (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n[1]), .start(start[1]),
    .m_axi_araddr(araddr[1]), .m_axi_arvalid(arvalid[1]), .m_axi_arready(arready[1]),
    .m_axi_rdata(rdata[1]), .m_axi_rresp(rresp[1]), .m_axi_rvalid(rvalid[1]), .m_axi_rready(rready[1]),
    .m_axi_awaddr(awaddr[1]), .m_axi_awvalid(awvalid[1]), .m_axi_awready(awready[1]),
    .m_axi_wdata(wdata[1]), .m_axi_wstrb(wstrb[1]), .m_axi_wvalid(wvalid[1]), .m_axi_wready(wready[1]),
    .m_axi_bresp(bresp[1]), .m_axi_bvalid(bvalid[1]), .m_axi_bready(bready[1]),
    .cpu_fetch_enable(cfe[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
    .word_count(wc_b), .checksum(checksum[1])
  );

  axil_boot_dma #(.STOP_SIG_EN(1'b1), .MAX_WORDS(1024), .AUTO_START(1'b0)) dut_c (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n[2]), .start(start[2]),
    .m_axi_araddr(araddr[2]), .m_axi_arvalid(arvalid[2]), .m_axi_arready(arready[2]),
    .m_axi_rdata(rdata[2]), .m_axi_rresp(rresp[2]), .m_axi_rvalid(rvalid[2]), .m_axi_rready(rready[2]),
    .m_axi_awaddr(awaddr[2]), .m_axi_awvalid(awvalid[2]), .m_axi_awready(awready[2]),
    .m_axi_wdata(wdata[2]), .m_axi_wstrb(wstrb[2]), .m_axi_wvalid(wvalid[2]), .m_axi_wready(wready[2]),
    .m_axi_bresp(bresp[2]), .m_axi_bvalid(bvalid[2]), .m_axi_bready(bready[2]),
    .cpu_fetch_enable(cfe[2]), .busy(busy[2]), .done(done[2]), .error(error[2]),
    .word_count(wc_c), .checksum(checksum[2])
  );

  // Slave model per DUT: zero-wait reads, programmable AW/W ready delays, one-shot read error injection,
  // and a protocol monitor counting valid drops, unstable payloads, duplicate valids and bad strobes.
  for (genvar gi = 0; gi < 3; gi++) begin : g_slv
    logic [31:0] src_mem [16];
    logic [31:0] dst_mem [16];
    int          rd_cnt, wr_cnt, aw_hs, w_hs, prot_err, aw_wait, w_wait;
    logic        aw_got, w_got, rvalid_r, bvalid_r, ar_pend, aw_pend, w_pend;
    logic [31:0] rdata_r, aw_a, w_d, first_ar, araddr_q, awaddr_q, wdata_q;
    logic [1:0]  rresp_r;
    logic [31:0] ridx, widx;

    assign ridx        = (araddr[gi] - 32'h2000) >> 2;
    assign widx        = (aw_a - 32'h4000) >> 2;
    assign arready[gi] = 1'b1;
    assign awready[gi] = awvalid[gi] && !aw_got && (aw_wait >= aw_dly[gi]);
    assign wready[gi]  = wvalid[gi] && !w_got && (w_wait >= w_dly[gi]);
    assign rvalid[gi]  = rvalid_r;
    assign rdata[gi]   = rdata_r;
    assign rresp[gi]   = rresp_r;
    assign bvalid[gi]  = bvalid_r;
    assign bresp[gi]   = 2'b00;

    always @(posedge clk) begin
      if (!rst_n[gi]) begin
        rd_cnt <= 0; wr_cnt <= 0; aw_hs <= 0; w_hs <= 0; prot_err <= 0;
        aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
        rvalid_r <= 1'b0; bvalid_r <= 1'b0; ar_pend <= 1'b0; aw_pend <= 1'b0; w_pend <= 1'b0;
        rdata_r <= '0; rresp_r <= '0; aw_a <= '0; w_d <= '0; first_ar <= '0;
        araddr_q <= '0; awaddr_q <= '0; wdata_q <= '0;
        for (int k = 0; k < 16; k++) dst_mem[k] <= '0;
      end else begin
        ar_pend  <= arvalid[gi] && !arready[gi];
        aw_pend  <= awvalid[gi] && !awready[gi];
        w_pend   <= wvalid[gi] && !wready[gi];
        araddr_q <= araddr[gi];
        awaddr_q <= awaddr[gi];
        wdata_q  <= wdata[gi];
        if ((ar_pend && (!arvalid[gi] || araddr[gi] != araddr_q)) ||
            (aw_pend && (!awvalid[gi] || awaddr[gi] != awaddr_q)) ||
            (w_pend && (!wvalid[gi] || wdata[gi] != wdata_q)) ||
            (awvalid[gi] && aw_got) || (wvalid[gi] && w_got) ||
            (wvalid[gi] && wstrb[gi] != 4'hF))
          prot_err <= prot_err + 1;

        if (rvalid_r && rready[gi]) rvalid_r <= 1'b0;
        if (arvalid[gi] && arready[gi]) begin
          rd_cnt   <= rd_cnt + 1;
          if (rd_cnt == 0) first_ar <= araddr[gi];
          rvalid_r <= 1'b1;
          rdata_r  <= (ridx < 16) ? src_mem[ridx[3:0]] : 32'hDEAD_BEEF;
          rresp_r  <= (rd_cnt == err_rd[gi]) ? 2'b10 : 2'b00;
        end

        if (awvalid[gi] && awready[gi]) begin
          aw_got <= 1'b1; aw_a <= awaddr[gi]; aw_hs <= aw_hs + 1; aw_wait <= 0;
        end else if (awvalid[gi]) aw_wait <= aw_wait + 1;
        if (wvalid[gi] && wready[gi]) begin
          w_got <= 1'b1; w_d <= wdata[gi]; w_hs <= w_hs + 1; w_wait <= 0;
        end else if (wvalid[gi]) w_wait <= w_wait + 1;

        if (aw_got && w_got) begin
          if (widx < 16) dst_mem[widx[3:0]] <= w_d;
          wr_cnt   <= wr_cnt + 1;
          bvalid_r <= 1'b1;
          aw_got   <= 1'b0;
          w_got    <= 1'b0;
        end
        if (bvalid_r && bready[gi]) bvalid_r <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_term(input int idx, input int budget, input string tag);
    int n = 0;
    while (!(done[idx] || error[idx]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic restart_a(input int awd, input int wd, input int erd);
    rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    aw_dly[0] = awd; w_dly[0] = wd; err_rd[0] = erd;
    rst_n[0] = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = '0;
    start = '0;
    for (int k = 0; k < 3; k++) begin
      aw_dly[k] = 0; w_dly[k] = 0; err_rd[k] = -1;
    end
    for (int k = 0; k < 16; k++) begin
      g_slv[0].src_mem[k] = '0;
      g_slv[1].src_mem[k] = SIG;
      g_slv[2].src_mem[k] = '0;
    end
    g_slv[0].src_mem[0] = 32'h11; g_slv[0].src_mem[1] = 32'h22; g_slv[0].src_mem[2] = SIG;
    g_slv[2].src_mem[0] = 32'h55; g_slv[2].src_mem[1] = 32'h66; g_slv[2].src_mem[2] = SIG;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_busy", busy[0], 1'b0);
    check("rst_done", done[0], 1'b0);
    check("rst_error", error[0], 1'b0);
    check("rst_cfe", cfe[0], 1'b0);
    check("rst_valids", {arvalid[0], rready[0], awvalid[0], wvalid[0], bready[0]}, 5'b0);
    check("rst_araddr", araddr[0], 32'h0);
    check("rst_wdata", wdata[0], 32'h0);
    check("rst_wc", wc_a, 11'd0);
    check("rst_checksum", checksum[0], 32'h0);
    check("wstrb", wstrb[0], 4'hF);

    // Signature-terminated copy with zero-wait slave
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("auto_ar", {arvalid[0], busy[0]}, 2'b11);
    check("auto_araddr", araddr[0], 32'h2000);
    wait_term(0, 200, "sig_term");
    check("sig_dst0", g_slv[0].dst_mem[0], 32'h11);
    check("sig_dst1", g_slv[0].dst_mem[1], 32'h22);
    check("sig_dst2", g_slv[0].dst_mem[2], 32'h0);
    check("sig_wc", wc_a, 11'd2);
    check("sig_flags", {done[0], cfe[0], error[0], busy[0]}, 4'b1100);
    check("sig_checksum", checksum[0], 32'h33 & SUM_MASK);
    check("sig_rd_cnt", g_slv[0].rd_cnt, 3);
    check("sig_prot", g_slv[0].prot_err, 0);

    // AW accepted 3 cycles before W, then the reverse
    restart_a(0, 3, -1);
    wait_term(0, 300, "awfirst_term");
    check("awfirst_hs", {g_slv[0].aw_hs[7:0], g_slv[0].w_hs[7:0], g_slv[0].wr_cnt[7:0]}, 24'h020202);
    check("awfirst_dst1", g_slv[0].dst_mem[1], 32'h22);
    check("awfirst_prot", g_slv[0].prot_err, 0);
    restart_a(3, 0, -1);
    wait_term(0, 300, "wfirst_term");
    check("wfirst_hs", {g_slv[0].aw_hs[7:0], g_slv[0].w_hs[7:0], g_slv[0].wr_cnt[7:0]}, 24'h020202);
    check("wfirst_dst0", g_slv[0].dst_mem[0], 32'h11);
    check("wfirst_prot", g_slv[0].prot_err, 0);

    // Reset while a write is outstanding
    restart_a(3, 3, -1);
    n = 0;
    while (!(awvalid[0] && wvalid[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midwr_seen", 32'(n < 100), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    check("midwr_valids", {arvalid[0], rready[0], awvalid[0], wvalid[0], bready[0]}, 5'b0);
    check("midwr_flags", {busy[0], done[0], error[0], cfe[0]}, 4'b0);
    check("midwr_awaddr", awaddr[0], 32'h0);
    @(negedge clk);
    restart_a(0, 0, -1);
    wait_term(0, 200, "midwr_term");
    check("midwr_first_ar", g_slv[0].first_ar, 32'h2000);
    check("midwr_dst0", g_slv[0].dst_mem[0], 32'h11);
    check("midwr_wc", wc_a, 11'd2);
    check("midwr_checksum", checksum[0], 32'h33 & SUM_MASK);

    // Error response on the second read
    restart_a(0, 0, 1);
    wait_term(0, 200, "err_term");
    repeat (5) @(negedge clk);
    check("err_flags", {error[0], done[0], cfe[0], busy[0]}, 4'b1000);
    check("err_wc", wc_a, 11'd1);
    check("err_valids", {arvalid[0], rready[0], awvalid[0], wvalid[0], bready[0]}, 5'b0);
    check("err_rd_cnt", g_slv[0].rd_cnt, 2);
    check("err_checksum", checksum[0], 32'h11 & SUM_MASK);

    // Count-only termination: signature words are copied, limit of 4 wins
    rst_n[1] = 1'b1;
    wait_term(1, 400, "cnt_term");
    check("cnt_wc", wc_b, 3'd4);
    check("cnt_flags", {done[1], cfe[1], error[1]}, 3'b110);
    check("cnt_rd_cnt", g_slv[1].rd_cnt, 4);
    check("cnt_wr_cnt", g_slv[1].wr_cnt, 4);
    check("cnt_dst3", g_slv[1].dst_mem[3], SIG);
    check("cnt_dst4", g_slv[1].dst_mem[4], 32'h0);
    check("cnt_checksum", checksum[1], 32'hF7B7_8000 & SUM_MASK);

    // Manual start: idle until pulsed, later pulses ignored
    rst_n[2] = 1'b1;
    repeat (10) @(negedge clk);
    check("man_idle_rd", g_slv[2].rd_cnt, 0);
    check("man_idle", {arvalid[2], busy[2]}, 2'b00);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    check("man_started", {arvalid[2], busy[2]}, 2'b11);
    repeat (3) @(negedge clk);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    wait_term(2, 200, "man_term");
    check("man_dst", {g_slv[2].dst_mem[0], g_slv[2].dst_mem[1]}, 64'h55_0000_0066 << 0 == 0 ? 64'h0 : {32'h55, 32'h66});
    check("man_wc", wc_c, 11'd2);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    repeat (5) @(negedge clk);
    check("man_rd_cnt", g_slv[2].rd_cnt, 3);
    check("man_hold", {done[2], busy[2], arvalid[2]}, 3'b100);
    check("man_prot", g_slv[2].prot_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_boot_dma.md
AXIL_BOOT_DMA -- requirements
Module: axil_boot_dma

Interface
REQ-001 Parameter SRC_BASE, 32'h0000_2000, first source word address.
REQ-002 Parameter DST_BASE, 32'h0000_4000, first destination word address.
REQ-003 Parameter MAX_WORDS, 1024, copy limit in words (1..65535).
REQ-004 Parameter STOP_SIG_EN, 1, 1 = stop on signature word; 0 = count-only termination.
REQ-005 Parameter STOP_SIGNATURE, 32'hBDED_E000, terminating source word.
REQ-006 Parameter AUTO_START, 1, 1 = start one cycle after reset release; 0 = wait for start.
REQ-007 Ports: m_axi_aclk in 1, clock; m_axi_aresetn in 1, reset, asynchronous, active-low.
REQ-008 Ports: start in 1, start pulse (ignored when AUTO_START=1 or not IDLE).
REQ-009 Ports: AXI4-Lite master set m_axi_ar{addr[32],valid}/arready; rdata[32], rresp[2], rvalid, rready; aw{addr[32],valid}/awready; wdata[32], wstrb[4], wvalid/wready; bresp[2], bvalid, bready.
REQ-010 Ports: cpu_fetch_enable out 1; busy out 1; done out 1; error out 1; word_count out CW=$clog2(MAX_WORDS+1); checksum out 32.

Function
REQ-011 States SHALL be IDLE, AR, R, WR, B, DONE, ERR.
REQ-012 IDLE -> AR on AUTO_START=1 (first cycle after reset) or on start=1 when AUTO_START=0.
REQ-013 AR: araddr = src, arvalid=1 held until arready sampled high; then arvalid=0, rready=1, -> R.
REQ-014 R: on rvalid&rready: rready=0; rresp!=0 -> ERR; else STOP_SIG_EN and rdata==STOP_SIGNATURE -> DONE (word not written); else latch data -> WR.
REQ-015 WR: awvalid and wvalid asserted together in the same cycle; each deasserts independently on its own handshake; -> B with bready=1 once both handshakes done (same or different cycles).
REQ-016 B: on bvalid&bready: bready=0; bresp!=0 -> ERR; else src+=4, dst+=4, word_count+=1; word_count+1==MAX_WORDS -> DONE, else -> AR.
REQ-017 Address arithmetic 32-bit modulo 2^32; no alignment check (bases word-aligned by construction).
REQ-018 wstrb SHALL be constant 4'b1111.
REQ-019 DONE: done=1, cpu_fetch_enable=1, terminal until reset.
REQ-020 ERR: error=1, cpu_fetch_enable stays 0, all valid/ready low, terminal until reset.
REQ-021 busy=1 in AR, R, WR, B only.
REQ-022 valid signals SHALL never drop before handshake; addr/data stable while valid high.
REQ-023 Signature in the MAX_WORDS+1-th position not read: count limit wins.

Reset
REQ-024 Asynchronous assertion: state=IDLE, all valid/ready=0, addresses=0, wdata=0, done=error=cpu_fetch_enable=busy=0, word_count=0, checksum=0, src=SRC_BASE, dst=DST_BASE.
REQ-025 Reset mid-transfer abandons the transaction immediately; restart copies from SRC_BASE.

Configuration
REQ-026 Macro AXIL_BOOT_DMA_CHECKSUM_EN defined: checksum = 32-bit wrapping sum of every word successfully written (updated on bresp OKAY).
REQ-027 Macro undefined: checksum tied to 0, no adder synthesised.

Structure
REQ-028 Package axil_dma_pkg: state enum type, AXI resp constants (OKAY=2'b00), default STOP_SIGNATURE.
REQ-029 Single module, no sub-module; the FSM is the sole sequential element.

Verification
REQ-030 AUTO_START=1, source 0x2000={0x11,0x22,0xBDEDE000}, zero-wait slave -> 0x4000=0x11, 0x4004=0x22, word_count=2, done=1, cpu_fetch_enable=1, checksum=0x33 (macro on).
REQ-031 STOP_SIG_EN=0, MAX_WORDS=4, source all 0xBDEDE000 -> 4 words copied, DONE after 4th B.
REQ-032 Slave awready 3 cycles before wready, then reversed -> both handshakes complete, single write per word, no duplicate valid.
REQ-033 rresp=2'b10 on 2nd read -> ERR, error=1, word_count=1, cpu_fetch_enable=0.
REQ-034 Reset asserted during WR with wvalid high -> all outputs reset same cycle; after release copy restarts at 0x2000.
REQ-035 AUTO_START=0: no AR until start pulse; start during busy ignored.
